edf_irq_claimer: RTL

Core-side claim unit for the EDF interrupt controller. It takes the controller's earliest-deadline interrupt offer (`id`/`deadline`/`valid`) and presents it to the hart as a level interrupt. When the hart accepts, it issues the one-cycle claim (`ready`) back to the controller. It keeps a stack of preempted handler contexts so an interrupt with a strictly earlier deadline can nest on top of a running handler.

---
 rtl/edf_ic_pkg.sv | 20 ++
 rtl/edf_ctx_stack.sv | 53 +++++
 rtl/edf_irq_claimer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/edf_ic_pkg.sv
// Shared types for the EDF interrupt controller: context payload and claimer states.
package edf_ic_pkg;

  localparam int unsigned IcNrIrqs  = 4;
  localparam int unsigned IcTsWidth = 64;
  localparam int unsigned IcIdWidth = $clog2(IcNrIrqs);

  typedef enum logic [1:0] {
    CL_WAIT  = 2'd0,
    CL_OFFER = 2'd1,
    CL_CLAIM = 2'd2,
    CL_HOLD  = 2'd3
  } claim_state_e;

  typedef struct packed {
    logic [IcIdWidth-1:0] id;
    logic [IcTsWidth-1:0] dl;
  } ctx_t;

endpackage

// File: rtl/edf_ctx_stack.sv
// Synchronous LIFO of preempted handler contexts; push and pop are never issued together.
module edf_ctx_stack
  import edf_ic_pkg::*;
#(
  parameter int unsigned StackDepth = 4,
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  ctx_t                  data_i,
  output ctx_t                  top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrWidth = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  ctx_t                  mem_q [StackDepth];
  logic [DepthWidth-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DepthWidth'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DepthWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage needs no reset: depth alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[AddrWidth'(depth_q)] <= data_i;
    end
  end

  assign full_o  = (depth_q == DepthWidth'(StackDepth));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign top_o   = empty_o ? '0 : mem_q[AddrWidth'(depth_q - DepthWidth'(1))];

endmodule

// File: rtl/edf_irq_claimer.sv
// Core-side claim unit: offers the controller's earliest-deadline IRQ to the hart,
// claims it on ack and nests strictly-earlier deadlines over a stack of contexts.
module edf_irq_claimer
  import edf_ic_pkg::*;
#(
  parameter int unsigned NrIrqs     = 4,
  parameter int unsigned TsWidth    = 64,
  parameter int unsigned StackDepth = 4,
  localparam int unsigned IdWidth    = $clog2(NrIrqs),
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IdWidth-1:0]    irq_id_i,
  input  logic [TsWidth-1:0]    irq_dl_i,
  input  logic                  irq_valid_i,
  output logic                  irq_ready_o,
  output logic                  core_irq_o,
  output logic [IdWidth-1:0]    core_irq_id_o,
  input  logic                  core_ack_i,
  input  logic                  core_done_i,
  output logic                  active_o,
  output logic [IdWidth-1:0]    active_id_o,
  output logic [DepthWidth-1:0] depth_o
);

  claim_state_e state_q, state_d;
  ctx_t         pend_q, pend_d;
  ctx_t         act_q, act_d;
  logic         act_valid_q, act_valid_d;
  logic         core_irq_q, core_irq_d;
  logic         irq_ready_q, irq_ready_d;

  ctx_t                  in_ctx_c;
  ctx_t                  stk_top_c;
  logic                  stk_full_c, stk_empty_c;
  logic                  push_c, pop_c, pop_req_c;
  logic                  eligible_c;
  logic [DepthWidth-1:0] stk_depth_c;

  edf_ctx_stack #(
    .StackDepth (StackDepth)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (act_q),
    .top_o   (stk_top_c),
    .depth_o (stk_depth_c),
    .full_o  (stk_full_c),
    .empty_o (stk_empty_c)
  );

  assign in_ctx_c   = '{id: irq_id_i, dl: irq_dl_i};
  // Equal deadlines never preempt; a full stack blocks nesting entirely.
  assign eligible_c = irq_valid_i &&
                      (!act_valid_q || ((irq_dl_i < act_q.dl) && !stk_full_c));

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    act_d       = act_q;
    act_valid_d = act_valid_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    pop_req_c   = 1'b0;

    case (state_q)
      CL_WAIT: begin
        if (eligible_c) begin
          pend_d  = in_ctx_c;
          state_d = CL_OFFER;
        end else if (core_done_i) begin
          pop_req_c = 1'b1;
        end
      end
      CL_OFFER: begin
        if (core_done_i) begin
          pop_req_c = 1'b1;
          state_d   = CL_WAIT;
        end else if (core_ack_i) begin
          state_d = (irq_valid_i && (irq_id_i == pend_q.id)) ? CL_CLAIM : CL_WAIT;
        end else if (eligible_c) begin
          pend_d = in_ctx_c;
        end else begin
          state_d = CL_WAIT;
        end
      end
      CL_CLAIM: begin
        push_c      = act_valid_q;
        act_d       = pend_q;
        act_valid_d = 1'b1;
        state_d     = CL_HOLD;
      end
      CL_HOLD: begin
        state_d = CL_WAIT;
      end
      default: begin
        state_d = CL_WAIT;
      end
    endcase

    // Return from handler: resume the preempted context or go idle.
    if (pop_req_c && act_valid_q) begin
      if (stk_empty_c) begin
        act_valid_d = 1'b0;
      end else begin
        act_d = stk_top_c;
        pop_c = 1'b1;
      end
    end

    core_irq_d  = (state_d == CL_OFFER);
    irq_ready_d = (state_d == CL_CLAIM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CL_WAIT;
      pend_q      <= '0;
      act_q       <= '0;
      act_valid_q <= 1'b0;
      core_irq_q  <= 1'b0;
      irq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      act_valid_q <= act_valid_d;
      core_irq_q  <= core_irq_d;
      irq_ready_q <= irq_ready_d;
    end
  end

  assign irq_ready_o   = irq_ready_q;
  assign core_irq_o    = core_irq_q;
  assign core_irq_id_o = pend_q.id;
  assign active_o      = act_valid_q;
  assign active_id_o   = act_q.id;
  assign depth_o       = stk_depth_c;

endmodule
